fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N_INSTR, default 32: instruction memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter DEPTH, default 2: prefetch buffer entries, power of two, at least 2.
REQ-004 clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 redirect_valid  in  1: flush and restart fetch at redirect_pc.
REQ-007 redirect_pc  in  32: new fetch byte address.
REQ-008 imem_addr  out  $clog2(N_INSTR*4): byte address to instruction memory; combinational read.
REQ-009 imem_instr  in  InstructionSize: word returned for imem_addr in the same cycle.
REQ-010 out_valid  out  1: out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  in  1: consumer accepts; transfer when out_valid and out_ready are both high.
REQ-012 out_instr  out  InstructionSize: head-of-buffer instruction.
REQ-013 out_pc  out  32: byte address of out_instr.
REQ-014 fetch_fault  out  1: fetch halted on a misaligned or out-of-range PC.

Function
REQ-015 fetch_pc is a 32-bit register; imem_addr shall equal fetch_pc[$clog2(N_INSTR*4)-1:0].
REQ-016 A fetch occurs in a cycle when rst=0, redirect_valid=0, fetch_fault=0, fetch_pc is legal, and the buffer is not full or a pop occurs in the same cycle.
REQ-017 A fetch pushes {fetch_pc, imem_instr} into the buffer and sets fetch_pc to fetch_pc+4 (32-bit wrap).
REQ-018 out_valid shall be high when the buffer is non-empty and redirect_valid=0; outputs shall come from registered buffer state only, with no combinational path from imem_instr.
REQ-019 A pop occurs on out_valid and out_ready; pushes and pops in the same cycle keep occupancy unchanged, including when the buffer is full or holds one entry.
REQ-020 A fetched word shall reach out_valid one cycle after its fetch cycle when the buffer was empty.
REQ-021 With out_ready held high and a legal PC, sustained throughput shall be one instruction per cycle.
REQ-022 On redirect_valid, the buffer shall be flushed, no fetch and no pop shall occur, fetch_pc <= redirect_pc, and fetch_fault <= 0; redirect takes priority over every other event except rst.
REQ-023 A PC is illegal if PC[1:0]!=0 or PC > N_INSTR*4-4.
REQ-024 In a cycle with no fetch due to an illegal fetch_pc, fetch_fault <= 1, with no push and fetch_pc held.
REQ-025 fetch_fault shall persist until redirect or reset.
REQ-026 Already-buffered entries shall still drain normally while fetch_fault=1.
REQ-027 Buffer state machine: EMPTY, PARTIAL, FULL, derived from occupancy.
REQ-028 Occupancy shall be DEPTH+1 counts wide, and read/write pointers shall wrap modulo DEPTH.
REQ-029 out_instr and out_pc shall hold their values while out_valid=1 and out_ready=0.

Reset
REQ-030 On rst: fetch_pc <= RESET_PC, buffer empty, out_valid=0, fetch_fault=0; out_instr and out_pc are 0.
REQ-031 rst asserted mid-stream discards all buffered entries and takes priority over redirect_valid.
REQ-032 The first fetch occurs in the first cycle with rst=0.

Structure
REQ-033 InstructionSize and a new FetchDepthDefault constant shall live in package rv32i_defs.
REQ-034 The buffer shall be one sub-module, fetch_fifo (push/pop/full/empty, parameterised width and depth), with the PC and fault logic in fetch_unit.

Verification
REQ-035 Reset release with out_ready=1 and memory words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193 -> out_pc 0,4,8,12 on consecutive cycles starting one cycle after the first fetch, instr matching.
REQ-036 out_ready=0 for 5 cycles after reset -> buffer fills to DEPTH, imem_addr holds 8 (DEPTH=2), out_pc stays 0; raise out_ready -> in-order drain without gaps.
REQ-037 Redirect to 0x40 while the buffer is full -> out_valid=0 that cycle, next out_pc=0x40, no stale entry emitted.
REQ-038 Redirect to 0x42 -> fetch_fault=1 the following cycle, out_valid stays 0; then redirect to 0x10 -> fault clears, out_pc=0x10.
REQ-039 N_INSTR=32, sequential run from 0x70 -> instructions 0x70..0x7C delivered, then fetch_fault=1 with PC 0x80 and no push.
REQ-040 rst pulse while the buffer holds 2 entries with redirect_valid=1 -> empty buffer, fetch_pc=RESET_PC, fetch_fault=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path.
// Contents:
//   InstructionSize   - width of one instruction word in bits
//   FetchDepthDefault - default number of prefetch buffer entries
//   buf_state_e       - prefetch buffer occupancy state
//   pc_is_legal()     - word-aligned and inside instruction memory
package rv32i_defs;

    localparam int InstructionSize   = 32;
    localparam int FetchDepthDefault = 2;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_PARTIAL = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    // last_pc is the byte address of the final word in instruction memory
    function automatic logic pc_is_legal(input logic [31:0] pc, input logic [31:0] last_pc);
        return (pc[1:0] == 2'b00) && (pc <= last_pc);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: a small FIFO of {pc, instruction} entries.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (clears contents to zero)
//   flush         - discard all entries (pointers and occupancy only)
//   push, din     - write an entry; accepted when not full or when popping
//   pop           - remove the head entry; ignored when empty
//   dout          - head entry, taken straight from the storage registers
//   full, empty   - occupancy flags, decoded from the registered state
module fetch_fifo
    import rv32i_defs::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = FetchDepthDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             push_s;
    logic             pop_s;
    buf_state_e       state_r;
    buf_state_e       state_nxt_s;

    // Accepted push/pop, next occupancy and the state it maps to
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        count_nxt_s = count_r;
        state_nxt_s = state_r;
        if (flush) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            pop_s  = pop && (state_r != BUF_EMPTY);
            // A pop frees the head slot this cycle, so a full buffer can still accept
            push_s = push && ((state_r != BUF_FULL) || pop_s);
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
        end
        if (count_nxt_s == {CW{1'b0}}) begin
            state_nxt_s = BUF_EMPTY;
        end else if (count_nxt_s == CW'(DEPTH)) begin
            state_nxt_s = BUF_FULL;
        end else begin
            state_nxt_s = BUF_PARTIAL;
        end
    end

    // Buffer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (state_r == BUF_FULL);
    assign empty = (state_r == BUF_EMPTY);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, prefetch buffer and fault latch.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   redirect_valid, redirect_pc - flush the buffer and restart fetch at redirect_pc
//   imem_addr, imem_instr       - combinational-read instruction memory port
//   out_valid, out_ready        - valid/ready handshake towards the decoder
//   out_instr, out_pc           - head-of-buffer instruction and its byte address
//   fetch_fault                 - fetch stopped on a misaligned or out-of-range PC
module fetch_unit
    import rv32i_defs::*;
#(
    parameter int          N_INSTR  = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = FetchDepthDefault
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                redirect_valid,
    input  logic [31:0]                         redirect_pc,
    output logic [$clog2(N_INSTR*4)-1:0]        imem_addr,
    input  logic [InstructionSize-1:0]          imem_instr,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [InstructionSize-1:0]          out_instr,
    output logic [31:0]                         out_pc,
    output logic                                fetch_fault
);

    localparam int          AW      = $clog2(N_INSTR * 4);
    localparam int          EW      = 32 + InstructionSize;
    localparam logic [31:0] LAST_PC = 32'(N_INSTR * 4 - 4);

    logic [31:0]  fetch_pc_r;
    logic [31:0]  fetch_pc_nxt_s;
    logic         fault_r;
    logic         fault_nxt_s;
    logic         pc_legal_s;
    logic         fetch_s;
    logic         pop_s;
    logic         full_s;
    logic         empty_s;
    logic [EW-1:0] head_s;

    // Fetch/pop decisions and next PC/fault; redirect overrides everything but reset
    always_comb begin
        pc_legal_s     = pc_is_legal(fetch_pc_r, LAST_PC);
        out_valid      = !empty_s && !redirect_valid;
        pop_s          = out_valid && out_ready;
        fetch_s        = 1'b0;
        fetch_pc_nxt_s = fetch_pc_r;
        fault_nxt_s    = fault_r;
        if (redirect_valid) begin
            fetch_pc_nxt_s = redirect_pc;
            fault_nxt_s    = 1'b0;
        end else if (fault_r) begin
            fault_nxt_s = 1'b1;
        end else if (!pc_legal_s) begin
            fault_nxt_s = 1'b1;
        end else begin
            fetch_s = !full_s || pop_s;
            if (fetch_s) begin
                fetch_pc_nxt_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
        end
    end

    // PC and fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            fault_r    <= 1'b0;
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            fault_r    <= fault_nxt_s;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (fetch_s),
        .pop   (pop_s),
        .din   ({fetch_pc_r, imem_instr}),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign imem_addr   = fetch_pc_r[AW-1:0];
    assign out_pc      = head_s[EW-1:InstructionSize];
    assign out_instr   = head_s[InstructionSize-1:0];
    assign fetch_fault = fault_r;

endmodule
